// File: rtl/aes_pkg.sv
// Shared constants, mode encoding and scheduler FSM states
// for the AES job scheduler and its arbiter.
package aes_pkg;

    localparam int AES_BLK_W    = 128;
    localparam int AES_ROUNDS   = 10;
    localparam int AES_CORE_LAT = 11;

    typedef enum logic {
        AES_ENC = 1'b0,
        AES_DEC = 1'b1
    } aes_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Two-requester round-robin arbiter.
// Ports: clk, rst_n (async low), req_i[1:0], advance_i (grant taken),
//        grant_o[1:0] (one-hot or zero), ptr_o (port favoured on conflict).
module aes_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o,
    output logic       ptr_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // The pointer only moves on a contested grant; a lone requester
    // does not steal the other port's turn.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && (req_i == 2'b11)) begin
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one iterative AES core between two requesters, one job at a time.
// Ports: req_* (per-port job in, valid/ready), rsp_* (per-port result out,
//        shared data/err), core_* (start/abort pulses, held operands,
//        done/dout back), busy (FSM not idle).
module aes_job_scheduler
    import aes_pkg::*;
#(
    parameter int DATA_W      = AES_BLK_W,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_mode,
    input  logic [2*DATA_W-1:0] req_data,
    input  logic [2*DATA_W-1:0] req_key,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    output logic                core_start,
    output logic                core_mode,
    output logic [DATA_W-1:0]   core_din,
    output logic [DATA_W-1:0]   core_key,
    output logic                core_abort,
    input  logic                core_done,
    input  logic [DATA_W-1:0]   core_dout,
    output logic                busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    sched_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              core_mode_q, core_mode_d;
    logic [DATA_W-1:0] core_din_q, core_din_d;
    logic [DATA_W-1:0] core_key_q, core_key_d;

    logic [1:0] grant;
    logic       rr_ptr;
    logic       advance;
    logic       sel;

    aes_rr_arbiter u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_valid),
        .advance_i (advance),
        .grant_o   (grant),
        .ptr_o     (rr_ptr)
    );

    assign sel = (req_valid == 2'b11) ? rr_ptr : req_valid[1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        core_mode_d = core_mode_q;
        core_din_d  = core_din_q;
        core_key_d  = core_key_q;
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        core_start  = 1'b0;
        core_abort  = 1'b0;
        advance     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // rst_n gate keeps ready low while reset is held,
                // even though the state already reads IDLE.
                if ((|grant) && rst_n) begin
                    req_ready   = grant;
                    advance     = 1'b1;
                    owner_d     = sel;
                    core_mode_d = req_mode[sel];
                    core_din_d  = sel ? req_data[2*DATA_W-1:DATA_W]
                                      : req_data[DATA_W-1:0];
                    core_key_d  = sel ? req_key[2*DATA_W-1:DATA_W]
                                      : req_key[DATA_W-1:0];
                    state_d     = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                core_start = 1'b1;
                cnt_d      = '0;
                state_d    = ST_WAIT;
            end

            ST_WAIT: begin
                // done is checked first so it wins over a same-cycle timeout
                if (core_done) begin
                    rsp_data_d = core_dout;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    core_abort = 1'b1;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            core_mode_q <= 1'b0;
            core_din_q  <= '0;
            core_key_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            core_mode_q <= core_mode_d;
            core_din_q  <= core_din_d;
            core_key_q  <= core_key_d;
        end
    end

    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign core_mode = core_mode_q;
    assign core_din  = core_din_q;
    assign core_key  = core_key_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
